// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_pkg
// Purpose  : Shared JK operation encoding and the JK next-state function.
// Revision : 1.0  initial release
// ============================================================================
package jk_pkg;

    // Operation selected by a {J,K} pair
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_t;

    // Bitwise form keeps X on j/k visible in the result instead of
    // collapsing it through a case/if decision.
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_next_bit.sv
`default_nettype none
// ============================================================================
// Module   : jk_next_bit
// Purpose  : Single combinational JK next-state cell.
// Revision : 1.0  initial release
// ============================================================================
module jk_next_bit
    import jk_pkg::*;
(
    input  logic i_j,
    input  logic i_k,
    input  logic i_q,
    output logic o_nxt
);

    assign o_nxt = jk_next(i_j, i_k, i_q);

endmodule : jk_next_bit
`default_nettype wire

// File: rtl/jk_ff.sv
`default_nettype none
// ============================================================================
// Module   : jk_ff
// Purpose  : Bank of WIDTH independent JK flip-flops with parallel load,
//            clock enable, change flags, and a bare combinational JK path.
// Revision : 1.0  initial release
// ============================================================================
module jk_ff
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] chg
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_chg;
    logic [WIDTH-1:0] w_jk_q;

    // Two cells per bit: one for the external q_in path, one fed by the bank
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_next_bit u_comb (
                .i_j   (j[gi]),
                .i_k   (k[gi]),
                .i_q   (q_in[gi]),
                .o_nxt (nxt[gi])
            );

            jk_next_bit u_reg (
                .i_j   (j[gi]),
                .i_k   (k[gi]),
                .i_q   (r_q[gi]),
                .o_nxt (w_jk_q[gi])
            );
        end : g_bit
    endgenerate

    // State register: load beats enable; chg flags bits that moved this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= RESET_VAL;
            r_chg <= '0;
        end else if (load) begin
            r_q   <= d;
            r_chg <= d ^ r_q;
        end else if (en) begin
            r_q   <= w_jk_q;
            r_chg <= w_jk_q ^ r_q;
        end else begin
            r_chg <= '0;
        end
    end

    assign q   = r_q;
    assign q_n = ~r_q;
    assign chg = r_chg;

endmodule : jk_ff
`default_nettype wire

// File: tb/tb_jk_ff.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_ff
// Purpose  : Self-checking bench for jk_ff (WIDTH=1 and WIDTH=4 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_ff;

    logic       clk = 1'b0;
    logic       rst;
    logic       en1, load1, d1, j1, k1, q_in_drv1, loop1;
    logic       q_in1, nxt1, q1, q_n1, chg1;
    logic       en4, load4;
    logic [3:0] d4, j4, k4, q_in4, nxt4, q4, q_n4, chg4;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] sb_q[$];
    logic [3:0] exp_v;

    always #5 clk = ~clk;

    // closed-loop mode feeds the registered state back into the comb path
    assign q_in1 = loop1 ? q1 : q_in_drv1;

    jk_ff #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .load(load1), .d(d1), .j(j1), .k(k1),
        .q_in(q_in1), .nxt(nxt1), .q(q1), .q_n(q_n1), .chg(chg1)
    );

    jk_ff #(.WIDTH(4), .RESET_VAL(4'b0000)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .load(load4), .d(d4), .j(j4), .k(k4),
        .q_in(q_in4), .nxt(nxt4), .q(q4), .q_n(q_n4), .chg(chg4)
    );

    task automatic check(input string name, input logic [3:0] obs);
        exp_v = sb_q.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, obs, exp_v, $time);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sb_q.push_back(4'b0000); check("reset_q", {3'b0, q1});
        sb_q.push_back(4'b0001); check("reset_qn", {3'b0, q_n1});
        sb_q.push_back(4'b0000); check("reset_chg", {3'b0, chg1});
        sb_q.push_back(4'b0000); check("reset_q4", q4);
    endtask

    task automatic test_comb();
        logic [2:0] vec [5] = '{3'b110, 3'b011, 3'b000, 3'b100, 3'b001};
        logic       req [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            {j1, k1, q_in_drv1} = vec[i];
            sb_q.push_back({3'b0, req[i]});
            #5;
            check("comb_nxt", {3'b0, nxt1});
        end
    endtask

    task automatic test_closed_loop();
        logic [1:0] jk  [5] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b00};
        logic       req [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        loop1 = 1'b1;
        en1   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            {j1, k1} = jk[i];
            sb_q.push_back({3'b0, req[i]});
            @(negedge clk);
            check("loop_q", {3'b0, q1});
        end
        en1   = 1'b0;
        loop1 = 1'b0;
    endtask

    task automatic test_async_reset();
        // q is 1 here and chg still 0; force chg=1 by loading 0 then 1
        load1 = 1'b1; d1 = 1'b0;
        @(negedge clk);
        d1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        sb_q.push_back(4'b0001); check("pre_rst_q", {3'b0, q1});
        sb_q.push_back(4'b0001); check("pre_rst_chg", {3'b0, chg1});
        #2 rst = 1'b1;
        #1;
        sb_q.push_back(4'b0000); check("async_q", {3'b0, q1});
        sb_q.push_back(4'b0001); check("async_qn", {3'b0, q_n1});
        sb_q.push_back(4'b0000); check("async_chg", {3'b0, chg1});
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_toggle();
        j1 = 1'b1; k1 = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back((i % 2 == 0) ? 4'b0001 : 4'b0000);
            sb_q.push_back(4'b0001);
            @(negedge clk);
            check("tgl_q", {3'b0, q1});
            check("tgl_chg", {3'b0, chg1});
        end
        en1 = 1'b0;
        sb_q.push_back(4'b0000);
        sb_q.push_back(4'b0000);
        @(negedge clk);
        check("hold_q", {3'b0, q1});
        check("hold_chg", {3'b0, chg1});
    endtask

    task automatic test_load_priority();
        load1 = 1'b1; d1 = 1'b1; j1 = 1'b0; k1 = 1'b1; en1 = 1'b0;
        sb_q.push_back(4'b0001);
        @(negedge clk);
        check("load_q", {3'b0, q1});
        load1 = 1'b0;
    endtask

    task automatic test_width4();
        load4 = 1'b1; d4 = 4'b0011;
        @(negedge clk);
        load4 = 1'b0;
        sb_q.push_back(4'b0011); check("w4_load", q4);
        j4 = 4'b1010; k4 = 4'b0110; en4 = 1'b1;
        sb_q.push_back(4'b1001);
        sb_q.push_back(4'b0110);
        @(negedge clk);
        en4 = 1'b0;
        check("w4_q", q4);
        check("w4_qn", q_n4);
        q_in4 = 4'b0011;
        sb_q.push_back(4'b1001);
        #1;
        check("w4_nxt", nxt4);
    endtask

    initial begin
        rst = 1'b1;
        en1 = 1'b0; load1 = 1'b0; d1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
        q_in_drv1 = 1'b0; loop1 = 1'b0;
        en4 = 1'b0; load4 = 1'b0; d4 = '0; j4 = '0; k4 = '0; q_in4 = '0;
        test_reset();
        test_comb();
        test_closed_loop();
        test_async_reset();
        test_toggle();
        test_load_priority();
        test_width4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_jk_ff
`default_nettype wire
